// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor. It processes one decimal digit per clock,
// least-significant digit first, under a start/busy/done handshake.
module bcd_serial_addsub #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic                cin,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             sub_q;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [3:0] a_k;
    logic [3:0] b_k;
    logic [3:0] b_adj;
    logic [4:0] t;
    logic [3:0] sum_k;
    logic       carry_nxt;
    logic       last_digit;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Digit k is picked with constant selects so the mux stays a plain compare tree.
    always_comb begin
        a_k = '0;
        b_k = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt == CNT_W'(i)) begin
                a_k = a_q[4*i +: 4];
                b_k = b_q[4*i +: 4];
            end
        end
        // Nine's complement of B; out-of-range digits simply wrap mod 16.
        b_adj = sub_q ? (4'd9 - b_k) : b_k;
        t     = {1'b0, a_k} + {1'b0, b_adj} + {4'd0, carry};
        if (t > 5'd9) begin
            sum_k     = t[3:0] + 4'd6;
            carry_nxt = 1'b1;
        end else begin
            sum_k     = t[3:0];
            carry_nxt = 1'b0;
        end
        last_digit = (cnt == CNT_W'(DIGITS - 1));
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        sub_q <= sub;
                        carry <= cin ^ sub;
                        err   <= has_bad_digit(a) | has_bad_digit(b);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cnt == CNT_W'(i)) sum[4*i +: 4] <= sum_k;
                    end
                    carry <= carry_nxt;
                    cnt   <= cnt + 1'b1;
                    if (last_digit) begin
                        cout  <= carry_nxt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub: a 4-digit instance for the main scenarios
// and a 1-digit instance for the single-digit latency case.
module tb_bcd_serial_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sub, cin;
    logic [15:0] a, b;
    logic [15:0] sum;
    logic        cout, busy, done, err;

    logic        start1, sub1, cin1;
    logic [3:0]  a1, b1;
    logic [3:0]  sum1;
    logic        cout1, busy1, done1, err1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_serial_addsub #(.DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .sum(sum), .cout(cout), .busy(busy), .done(done), .err(err)
    );

    bcd_serial_addsub #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .cin(cin1),
        .a(a1), .b(b1), .sum(sum1), .cout(cout1), .busy(busy1), .done(done1), .err(err1)
    );

    // Launch one operation, scramble the inputs right after the start edge, then watch
    // a fixed 10-cycle window. lat is the cycle index (1 = cycle after start edge) of the
    // first done pulse, or 0 if none arrived.
    task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                          input logic op_sub, input logic op_cin,
                          output logic [15:0] r_sum, output logic r_cout, output logic r_err,
                          output int lat, output int busy_cnt, output int done_cnt);
        @(negedge clk);
        a = op_a; b = op_b; sub = op_sub; cin = op_cin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~op_a; b = 16'h5555; sub = ~op_sub; cin = ~op_cin;
        lat = 0; busy_cnt = 0; done_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat == 0) lat = i;
            end
        end
        r_sum = sum; r_cout = cout; r_err = err;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({sum, cout, busy, done, err} !== 20'h0) begin
            $display("FAIL reset_outputs: got sum=%h cout=%b busy=%b done=%b err=%b, expected all zero",
                     sum, cout, busy, done, err);
            n_fail++;
        end
        n_checks++;
        if ({sum1, cout1, busy1, done1, err1} !== 8'h0) begin
            $display("FAIL reset_outputs_d1: got sum=%h cout=%b busy=%b done=%b, expected all zero",
                     sum1, cout1, busy1, done1);
            n_fail++;
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_add;
        logic [15:0] s; logic co, er; int lat, bc, dc;
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, s, co, er, lat, bc, dc);
        n_checks++;
        if ({s, co, er} !== {16'h6912, 1'b0, 1'b0}) begin
            $display("FAIL add_basic: got sum=%h cout=%b err=%b, expected sum=6912 cout=0 err=0", s, co, er);
            n_fail++;
        end
        n_checks++;
        if (lat != 5 || bc != 4 || dc != 1) begin
            $display("FAIL add_timing: got done_at=%0d busy_cycles=%0d done_pulses=%0d, expected 5/4/1", lat, bc, dc);
            n_fail++;
        end
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, s, co, er, lat, bc, dc);
        n_checks++;
        if ({s, co} !== {16'h0000, 1'b1}) begin
            $display("FAIL add_carry_ripple: got sum=%h cout=%b, expected sum=0000 cout=1", s, co);
            n_fail++;
        end
        run_op(16'h0000, 16'h0000, 1'b0, 1'b1, s, co, er, lat, bc, dc);
        n_checks++;
        if ({s, co} !== {16'h0001, 1'b0}) begin
            $display("FAIL add_cin: got sum=%h cout=%b, expected sum=0001 cout=0", s, co);
            n_fail++;
        end
        run_op(16'h0999, 16'h0001, 1'b0, 1'b0, s, co, er, lat, bc, dc);
        n_checks++;
        if ({s, co} !== {16'h1000, 1'b0}) begin
            $display("FAIL add_partial_ripple: got sum=%h cout=%b, expected sum=1000 cout=0", s, co);
            n_fail++;
        end
    endtask

    task automatic test_sub;
        logic [15:0] s; logic co, er; int lat, bc, dc;
        run_op(16'h5000, 16'h1234, 1'b1, 1'b0, s, co, er, lat, bc, dc);
        n_checks++;
        if ({s, co} !== {16'h3766, 1'b1}) begin
            $display("FAIL sub_no_borrow: got sum=%h cout=%b, expected sum=3766 cout=1", s, co);
            n_fail++;
        end
        run_op(16'h1234, 16'h5000, 1'b1, 1'b0, s, co, er, lat, bc, dc);
        n_checks++;
        if ({s, co} !== {16'h6234, 1'b0}) begin
            $display("FAIL sub_borrow: got sum=%h cout=%b, expected sum=6234 cout=0", s, co);
            n_fail++;
        end
        run_op(16'h4321, 16'h4321, 1'b1, 1'b0, s, co, er, lat, bc, dc);
        n_checks++;
        if ({s, co} !== {16'h0000, 1'b1}) begin
            $display("FAIL sub_equal: got sum=%h cout=%b, expected sum=0000 cout=1", s, co);
            n_fail++;
        end
        run_op(16'h0000, 16'h0000, 1'b1, 1'b1, s, co, er, lat, bc, dc);
        n_checks++;
        if ({s, co} !== {16'h9999, 1'b0}) begin
            $display("FAIL sub_borrow_in: got sum=%h cout=%b, expected sum=9999 cout=0", s, co);
            n_fail++;
        end
    endtask

    task automatic test_err;
        logic [15:0] s; logic co, er; int lat, bc, dc;
        // Digit 1 of A is 0xA: 10+0 > 9 gives 0 with carry, so the bitwise result is 0x0101.
        run_op(16'h00A0, 16'h0001, 1'b0, 1'b0, s, co, er, lat, bc, dc);
        n_checks++;
        if ({s, co, er} !== {16'h0101, 1'b0, 1'b1}) begin
            $display("FAIL err_flag: got sum=%h cout=%b err=%b, expected sum=0101 cout=0 err=1", s, co, er);
            n_fail++;
        end
        n_checks++;
        if (lat != 5 || dc != 1) begin
            $display("FAIL err_timing: got done_at=%0d done_pulses=%0d, expected 5/1", lat, dc);
            n_fail++;
        end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, s, co, er, lat, bc, dc);
        n_checks++;
        if ({s, co, er} !== {16'h0002, 1'b0, 1'b0}) begin
            $display("FAIL err_clears: got sum=%h cout=%b err=%b, expected sum=0002 cout=0 err=0", s, co, er);
            n_fail++;
        end
    endtask

    task automatic test_start_during_run;
        int dc, lat;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dc = 0; lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 2) begin
                a = 16'h9999; b = 16'h9999; sub = 1'b1; cin = 1'b1; start = 1'b1;
            end
            if (i == 3) start = 1'b0;
            if (done) begin
                dc++;
                if (lat == 0) lat = i;
            end
        end
        n_checks++;
        if ({sum, cout} !== {16'h3333, 1'b0}) begin
            $display("FAIL start_in_run_result: got sum=%h cout=%b, expected sum=3333 cout=0", sum, cout);
            n_fail++;
        end
        n_checks++;
        if (dc != 1 || lat != 5) begin
            $display("FAIL start_in_run_pulses: got done_pulses=%0d done_at=%0d, expected 1/5", dc, lat);
            n_fail++;
        end
    endtask

    task automatic test_reset_during_run;
        logic [15:0] s; logic co, er; int lat, bc, dc;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, sum, cout, done} !== 19'h0) begin
            $display("FAIL reset_in_run: got busy=%b sum=%h cout=%b done=%b, expected all zero", busy, sum, cout, done);
            n_fail++;
        end
        dc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dc++;
        end
        n_checks++;
        if (dc != 0) begin
            $display("FAIL reset_in_run_no_done: got done_pulses=%0d, expected 0", dc);
            n_fail++;
        end
        run_op(16'h0456, 16'h0789, 1'b0, 1'b0, s, co, er, lat, bc, dc);
        n_checks++;
        if ({s, co} !== {16'h1245, 1'b0} || lat != 5) begin
            $display("FAIL reset_then_op: got sum=%h cout=%b done_at=%0d, expected sum=1245 cout=0 done_at=5", s, co, lat);
            n_fail++;
        end
    endtask

    task automatic test_digits1;
        int lat, dc;
        @(negedge clk);
        a1 = 4'h7; b1 = 4'h5; sub1 = 1'b0; cin1 = 1'b0; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
        lat = 0; dc = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (done1) begin
                dc++;
                if (lat == 0) lat = i;
            end
        end
        n_checks++;
        if ({sum1, cout1, err1} !== {4'h2, 1'b1, 1'b0}) begin
            $display("FAIL d1_add: got sum=%h cout=%b err=%b, expected sum=2 cout=1 err=0", sum1, cout1, err1);
            n_fail++;
        end
        n_checks++;
        if (lat != 2 || dc != 1) begin
            $display("FAIL d1_timing: got done_at=%0d done_pulses=%0d, expected 2/1", lat, dc);
            n_fail++;
        end
        @(negedge clk);
        a1 = 4'h3; b1 = 4'h5; sub1 = 1'b1; cin1 = 1'b0; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({sum1, cout1} !== {4'h8, 1'b0}) begin
            $display("FAIL d1_sub: got sum=%h cout=%b, expected sum=8 cout=0", sum1, cout1);
            n_fail++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
        test_reset;
        test_add;
        test_sub;
        test_err;
        test_start_during_run;
        test_reset_during_run;
        test_digits1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
